// File: rtl/seq_bin2dec.sv
// Sequential binary-to-BCD converter (double-dabble, one input bit per clock) with
// start/busy/done handshake, leading-zero blanking and a saturating overflow flag.
// Optional two's-complement input when SEQ_BIN2DEC_SIGNED_EN is defined.
module seq_bin2dec #(
  parameter int BIN_W  = 7,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  lz,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   dout,
  output logic                  ovf,
  output logic                  neg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sticky_q, sticky_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   dout_q, dout_d;
  logic               ovf_q, ovf_d;
  logic [BIN_W-1:0]   shreg_q, shreg_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               lz_q, lz_d;
  logic [BCD_W-1:0]   bcd_adj;

  // Add-3 correction on every digit that would become >= 10 after doubling.
  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Digits above the highest nonzero digit become the blank code; zero blanks all.
  function automatic logic [BCD_W-1:0] blank_lz(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    logic             lead;
    r    = b;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (r[4*i +: 4] != 4'd0) lead = 1'b0;
      else if (lead)           r[4*i +: 4] = 4'hA;
    end
    return r;
  endfunction

  // The most negative input maps onto its own bit pattern, which is the correct
  // unsigned magnitude.
  function automatic logic [BIN_W-1:0] magnitude(input logic [BIN_W-1:0] b);
`ifdef SEQ_BIN2DEC_SIGNED_EN
    return b[BIN_W-1] ? (~b + 1'b1) : b;
`else
    return b;
`endif
  endfunction

`ifdef SEQ_BIN2DEC_SIGNED_EN
  logic neg_q, neg_d;
  logic negl_q, negl_d;
`endif

  assign bcd_adj = dabble_adj(bcd_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    done_d   = 1'b0;
    dout_d   = dout_q;
    ovf_d    = ovf_q;
    shreg_d  = shreg_q;
    bcd_d    = bcd_q;
    lz_d     = lz_q;
`ifdef SEQ_BIN2DEC_SIGNED_EN
    neg_d    = neg_q;
    negl_d   = negl_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d  = magnitude(bin);
          lz_d     = lz;
          bcd_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_W'(BIN_W - 1);
          state_d  = SHIFT;
`ifdef SEQ_BIN2DEC_SIGNED_EN
          negl_d   = bin[BIN_W-1];
`endif
        end
      end
      SHIFT: begin
        {bcd_d, shreg_d} = {bcd_adj[BCD_W-2:0], shreg_q, 1'b0};
        // A bit leaving the top digit means the value no longer fits.
        sticky_d = sticky_q | bcd_adj[BCD_W-1];
        if (cnt_q == '0) state_d = FINISH;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (sticky_q) begin
          dout_d = {DIGITS{4'h9}};
          ovf_d  = 1'b1;
        end else begin
          dout_d = lz_q ? blank_lz(bcd_q) : bcd_q;
          ovf_d  = 1'b0;
        end
`ifdef SEQ_BIN2DEC_SIGNED_EN
        neg_d = negl_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      done_q   <= 1'b0;
      dout_q   <= {DIGITS{4'hA}};
      ovf_q    <= 1'b0;
`ifdef SEQ_BIN2DEC_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      done_q   <= done_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
`ifdef SEQ_BIN2DEC_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  // Datapath registers are only meaningful after a start, so they carry no reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    bcd_q   <= bcd_d;
    lz_q    <= lz_d;
`ifdef SEQ_BIN2DEC_SIGNED_EN
    negl_q  <= negl_d;
`endif
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign dout = dout_q;
  assign ovf  = ovf_q;
`ifdef SEQ_BIN2DEC_SIGNED_EN
  assign neg  = neg_q;
`else
  assign neg  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_bin2dec.sv
// Bench for seq_bin2dec: vector table, random conversions against an arithmetic
// model, back-to-back throughput and reset-abort sequences.
module tb_seq_bin2dec;

  localparam int BIN_W  = 7;
  localparam int DIGITS = 2;
  localparam int DW     = 4 * DIGITS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [BIN_W-1:0]  bin = '0;
  logic              lz = 1'b0;
  logic              busy, done, ovf, neg;
  logic [DW-1:0]     dout;

  int vec_cnt = 0;
  int err_cnt = 0;

  seq_bin2dec #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin), .lz(lz),
    .busy(busy), .done(done), .dout(dout), .ovf(ovf), .neg(neg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Decimal digits by division; digit i is blank when the magnitude is below 10^i.
  task automatic model(input logic [BIN_W-1:0] b, input logic l,
                       output logic [DW-1:0] d, output logic o, output logic n);
    int mag, p;
    mag = int'(b);
    n   = 1'b0;
`ifdef SEQ_BIN2DEC_SIGNED_EN
    if (b[BIN_W-1]) begin
      mag = (1 << BIN_W) - int'(b);
      n   = 1'b1;
    end
`endif
    p = 1;
    for (int i = 0; i < DIGITS; i++) p = p * 10;
    o = (mag > p - 1);
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (o)                d[4*i +: 4] = 4'h9;
      else if (l && mag < p) d[4*i +: 4] = 4'hA;
      else                  d[4*i +: 4] = 4'((mag / p) % 10);
      p = p * 10;
    end
  endtask

  task automatic conv(input logic [BIN_W-1:0] b, input logic l, input logic [DW-1:0] ed,
                      input logic eo, input logic en, input string nm);
    int  n, busy_cnt;
    bit  seen;
    @(negedge clk);
    start = 1'b1; bin = b; lz = l;
    @(posedge clk); #1;
    start = 1'b0; bin = BIN_W'($urandom); lz = 1'($urandom);
    busy_cnt = busy ? 1 : 0;
    n = 0; seen = 1'b0;
    while (!seen && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
      else if (busy) busy_cnt++;
    end
    check({nm, " latency"}, 32'(n), 32'(BIN_W + 1));
    check({nm, " busy cycles"}, 32'(busy_cnt), 32'(BIN_W + 1));
    check({nm, " busy at done"}, 32'(busy), 32'(0));
    check({nm, " dout"}, 32'(dout), 32'(ed));
    check({nm, " ovf"}, 32'(ovf), 32'(eo));
    check({nm, " neg"}, 32'(neg), 32'(en));
    @(posedge clk); #1;
    check({nm, " done width"}, 32'(done), 32'(0));
    check({nm, " dout hold"}, 32'(dout), 32'(ed));
  endtask

  typedef struct {
    logic [BIN_W-1:0] b;
    logic             l;
    logic [DW-1:0]    d;
    logic             o;
    logic             n;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [DW-1:0] ed;
    logic          eo, en;
    logic [BIN_W-1:0] rb;
    logic          rl;
    int            n, dones;

`ifdef SEQ_BIN2DEC_SIGNED_EN
    tbl.push_back('{7'b1011011, 1'b0, 8'h37, 1'b0, 1'b1});
    tbl.push_back('{7'd7,       1'b1, 8'hA7, 1'b0, 1'b0});
    tbl.push_back('{7'd0,       1'b1, 8'hAA, 1'b0, 1'b0});
    tbl.push_back('{7'd0,       1'b0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{7'b1000000, 1'b0, 8'h64, 1'b0, 1'b1});
    tbl.push_back('{7'd63,      1'b1, 8'h63, 1'b0, 1'b0});
    tbl.push_back('{7'b1111111, 1'b1, 8'hA1, 1'b0, 1'b1});
`else
    tbl.push_back('{7'd57,  1'b0, 8'h57, 1'b0, 1'b0});
    tbl.push_back('{7'd7,   1'b0, 8'h07, 1'b0, 1'b0});
    tbl.push_back('{7'd7,   1'b1, 8'hA7, 1'b0, 1'b0});
    tbl.push_back('{7'd0,   1'b1, 8'hAA, 1'b0, 1'b0});
    tbl.push_back('{7'd0,   1'b0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{7'd127, 1'b0, 8'h99, 1'b1, 1'b0});
    tbl.push_back('{7'd99,  1'b0, 8'h99, 1'b0, 1'b0});
    tbl.push_back('{7'd100, 1'b1, 8'h99, 1'b1, 1'b0});
    tbl.push_back('{7'd10,  1'b1, 8'h10, 1'b0, 1'b0});
    tbl.push_back('{7'd90,  1'b1, 8'h90, 1'b0, 1'b0});
    tbl.push_back('{7'd5,   1'b1, 8'hA5, 1'b0, 1'b0});
`endif

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset ovf", 32'(ovf), 32'(0));
    check("reset neg", 32'(neg), 32'(0));
    check("reset dout", 32'(dout), 32'({DIGITS{4'hA}}));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) conv(tbl[i].b, tbl[i].l, tbl[i].d, tbl[i].o, tbl[i].n, $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      rb = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
      rl = 1'($urandom_range(0, 1));
      model(rb, rl, ed, eo, en);
      conv(rb, rl, ed, eo, en, $sformatf("rand%0d bin=%0d lz=%0d", i, rb, rl));
    end

    // start held high: 12 then 34, one result every BIN_W+2 cycles
    @(negedge clk);
    start = 1'b1; bin = BIN_W'(12); lz = 1'b0;
    @(posedge clk); #1;
    bin = BIN_W'(34);
    dones = 0;
    for (n = 1; n <= 2 * (BIN_W + 2) + 2; n++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        if (dones == 1) begin
          model(BIN_W'(12), 1'b0, ed, eo, en);
          check("b2b first time", 32'(n), 32'(BIN_W + 1));
          check("b2b first dout", 32'(dout), 32'(ed));
        end else begin
          model(BIN_W'(34), 1'b0, ed, eo, en);
          check("b2b second time", 32'(n), 32'(2 * (BIN_W + 2) - 1));
          check("b2b second dout", 32'(dout), 32'(ed));
        end
      end
      if (n == 2 * (BIN_W + 2) - 1) start = 1'b0;
    end
    check("b2b done count", 32'(dones), 32'(2));
    check("b2b idle after", 32'(busy), 32'(0));

    // Saturate first so ovf is visibly cleared by the abort.
    model({BIN_W{1'b1}}, 1'b0, ed, eo, en);
    conv({BIN_W{1'b1}}, 1'b0, ed, eo, en, "pre-abort");
    @(negedge clk);
    start = 1'b1; bin = BIN_W'(57); lz = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'(0));
    check("abort done", 32'(done), 32'(0));
    check("abort ovf", 32'(ovf), 32'(0));
    check("abort neg", 32'(neg), 32'(0));
    check("abort dout", 32'(dout), 32'({DIGITS{4'hA}}));
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (BIN_W + 6) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort no done", 32'(dones), 32'(0));
    check("abort stays idle", 32'(busy), 32'(0));

    model(BIN_W'(57), 1'b1, ed, eo, en);
    conv(BIN_W'(57), 1'b1, ed, eo, en, "post-abort");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
